// File: rtl/mmc_pkg.sv
// rtl/mmc_pkg.sv - shared types and constants for the matrix-multiply sequencer
package mmc_pkg;

    localparam int N_DEFAULT      = 32;
    localparam int NUM_PE_DEFAULT = 4;
    localparam int MEM_LAT        = 1;
    localparam int ACC_W          = 21;
    localparam int CNT_W          = 5;

    localparam logic [CNT_W-1:0] CLR_VAL = 5'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Address width for a power-of-two depth, never narrower than one bit.
    function automatic int width_of(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mmc_index_gen.sv
// rtl/mmc_index_gen.sv - nested i/g/k loop counter with wrap and last-element flags
module mmc_index_gen
    import mmc_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int NUM_PE = NUM_PE_DEFAULT,
    localparam int GROUPS = N / NUM_PE,
    localparam int IW     = width_of(N),
    localparam int GW     = width_of(GROUPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] i,
    output logic [GW-1:0] g,
    output logic [IW-1:0] k,
    output logic          k_wrap,
    output logic          last
);

    logic g_wrap;
    logic i_wrap;

    assign k_wrap = (k == IW'(N - 1));
    assign g_wrap = (g == GW'(GROUPS - 1));
    assign i_wrap = (i == IW'(N - 1));
    assign last   = k_wrap && g_wrap && i_wrap;

    // k innermost, then g, then i; the last element wraps everything back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            g <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            g <= '0;
            k <= '0;
        end else if (advance) begin
            k <= k_wrap ? '0 : k + IW'(1);
            if (k_wrap) begin
                g <= g_wrap ? '0 : g + GW'(1);
                if (g_wrap) begin
                    i <= i_wrap ? '0 : i + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mmc_sequencer.sv
// rtl/mmc_sequencer.sv - read-address, clear-count and result-write sequencer for the MMC core
module mmc_sequencer
    import mmc_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int NUM_PE = NUM_PE_DEFAULT,
    localparam int GROUPS = N / NUM_PE,
    localparam int IW     = width_of(N),
    localparam int GW     = width_of(GROUPS),
    localparam int AW_A   = width_of(N * N),
    localparam int AW_B   = width_of(N * N / NUM_PE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW_A-1:0]  addr_a,
    output logic [AW_B-1:0]  addr_b,
    output logic             rd_en,
    output logic [CNT_W-1:0] counter0,
    output logic             wr_en,
    output logic [AW_B-1:0]  wr_addr
);

    state_t        state;
    state_t        state_next;
    logic          drain_cnt;
    logic          clear;
    logic [IW-1:0] i;
    logic [GW-1:0] g;
    logic [IW-1:0] k;
    logic          k_wrap;
    logic          last;
    logic          p1_valid;
    logic [IW-1:0] p1_i;
    logic [GW-1:0] p1_g;

    mmc_index_gen #(
        .N      (N),
        .NUM_PE (NUM_PE)
    ) u_index_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (rd_en),
        .i       (i),
        .g       (g),
        .k       (k),
        .k_wrap  (k_wrap),
        .last    (last)
    );

    // Strides are powers of two, so i*N+k and k*GROUPS+g are plain bit concatenations.
    assign addr_a = {i, k};
    assign addr_b = {k, g};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == S_DRAIN) && !drain_cnt;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        clear      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Clear count lines up with the returning read data one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter0 <= '0;
        end else begin
            counter0 <= rd_en ? (CNT_W'(k) + CNT_W'(1)) : '0;
        end
    end

    // Two-stage write pipe: last read -> data on bus -> sum registered in the units.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid <= 1'b0;
            p1_i     <= '0;
            p1_g     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
        end else begin
            p1_valid <= rd_en && k_wrap;
            if (rd_en && k_wrap) begin
                p1_i <= i;
                p1_g <= g;
            end
            wr_en <= p1_valid;
            if (p1_valid) begin
                wr_addr <= {p1_i, p1_g};
            end
        end
    end

endmodule

// File: tb/tb_mmc_sequencer.sv
// tb/tb_mmc_sequencer.sv - randomized self-checking bench for mmc_sequencer
module tb_mmc_sequencer;

    localparam int N  = 32;
    localparam int P  = 4;
    localparam int G  = N / P;
    localparam int R  = N * N * N / P;
    localparam int T  = R + 3;
    localparam int CD = N * N / P;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [9:0] addr_a;
    logic [7:0] addr_b;
    logic       rd_en;
    logic [4:0] counter0;
    logic       wr_en;
    logic [7:0] wr_addr;

    int vectors;
    int miscompares;
    int n;
    int wr_cnt;
    bit lit_en;

    int A [N*N];
    int B [P][CD];
    int C [P][CD];
    int a_q;
    int b_q [P];
    int acc [P];

    mmc_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .rd_en    (rd_en),
        .counter0 (counter0),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    // Model position: n = cycles since the accepted start (0 = idle).
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else if (n == 0) n <= start ? 1 : 0;
        else n <= (n == T) ? 0 : n + 1;
    end

    // Four computation units plus registered SRAMs.
    always @(posedge clk) begin
        a_q <= A[addr_a];
        for (int p = 0; p < P; p++) begin
            b_q[p] <= B[p][addr_b];
            acc[p] <= ((counter0 == 5'd1) ? 0 : acc[p]) + a_q * b_q[p];
            if (wr_en) C[p][wr_addr] <= acc[p];
        end
    end

    always @(negedge clk) begin
        int r;
        if (rst) begin
            if (n == 1) wr_cnt = 0;
            if (wr_en) wr_cnt++;
            chk("busy", busy, (n >= 1 && n <= R + 2));
            chk("done", done, (n == T));
            chk("rd_en", rd_en, (n >= 1 && n <= R));
            if (n >= 1 && n <= R) begin
                r = n - 1;
                chk("addr_a", addr_a, (r / (N * G)) * N + r % N);
                chk("addr_b", addr_b, (r % N) * G + (r / N) % G);
            end
            if (n >= 2 && n <= R + 1)
                chk("counter0", counter0, ((n - 2) % N + 1) % 32);
            chk("wr_en", wr_en, (n >= 3 && n <= R + 2 && (n - 3) % N == N - 1));
            if (wr_en) chk("wr_addr", wr_addr, (n - 3) / N);
            if (lit_en) begin
                case (n)
                    1: begin
                        chk("lit_busy1", busy, 1);
                        chk("lit_a1", addr_a, 0);
                        chk("lit_b1", addr_b, 0);
                    end
                    2: begin
                        chk("lit_a2", addr_a, 1);
                        chk("lit_b2", addr_b, 8);
                        chk("lit_c2", counter0, 1);
                    end
                    33: begin
                        chk("lit_a33", addr_a, 0);
                        chk("lit_b33", addr_b, 1);
                    end
                    34: begin
                        chk("lit_c34", counter0, 1);
                        chk("lit_wr34", wr_en, 1);
                        chk("lit_wa34", wr_addr, 0);
                    end
                    35: chk("lit_wr35", wr_en, 0);
                    8194: chk("lit_busy8194", busy, 1);
                    8195: begin
                        chk("lit_done", done, 1);
                        chk("lit_busy_end", busy, 0);
                        chk("lit_wrcnt", wr_cnt, 256);
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_addr_a"}, addr_a, 0);
        chk({tag, "_addr_b"}, addr_b, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_counter0"}, counter0, 0);
    endtask

    task automatic run_once(input bit lit, input bit noise, input int abort_at);
        int guard;
        lit_en = lit;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (1) begin
            @(negedge clk);
            guard++;
            if (abort_at > 0 && n == abort_at) begin
                start = 1'b0;
                rst = 1'b0;
                #1;
                check_zero("async_rst");
                repeat (3) @(negedge clk);
                rst = 1'b1;
                lit_en = 1'b0;
                return;
            end
            if (n == T) begin
                start = 1'b0;
                break;
            end
            if (guard > T + 20) begin
                chk("run_timeout", 0, 1);
                start = 1'b0;
                break;
            end
            if (noise) start = ($urandom_range(0, 63) == 0);
            else start = (n == 100 || n == 5000);
        end
        lit_en = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        wr_cnt = 0;
        lit_en = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        for (int x = 0; x < N * N; x++) A[x] = ((x / N) == (x % N)) ? 1 : 0;
        for (int p = 0; p < P; p++)
            for (int x = 0; x < CD; x++) begin
                B[p][x] = (x % G) * P + p;
                C[p][x] = -1;
            end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        run_once(1'b1, 1'b0, 0);
        for (int p = 0; p < P; p++)
            for (int x = 0; x < CD; x++)
                chk("c_bank", C[p][x], (x % G) * P + p);

        run_once(1'b0, 1'b0, 4000);
        run_once(1'b1, 1'b0, 0);
        run_once(1'b0, 1'b1, 0);
        run_once(1'b0, 1'b1, 0);
        run_once(1'b0, 1'b1, $urandom_range(10, R));
        run_once(1'b0, 1'b1, 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
